flash_wb_reader: RTL

//  Wishbone pipelined bus master that reads a contiguous block of 32-bit words from the QSPI

---
 rtl/flash_wb_reader_pkg.sv | 6 +
 rtl/flash_wb_reader_if.sv | 18 +
 rtl/flash_wb_reader_sync_fifo.sv | 43 ++++
 rtl/flash_wb_reader.sv | 102 ++++++++++
 4 files changed

// File: rtl/flash_wb_reader_pkg.sv
// flash_wb_reader_pkg: shared bus widths and FSM state encoding for the flash Wishbone reader
package flash_wb_reader_pkg;
   localparam int FLASH_ADDR_W = 22;
   localparam int FLASH_DATA_W = 32;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
endpackage

// File: rtl/flash_wb_reader_if.sv
// flash_wb_reader_if: pipelined Wishbone read link between the reader (master) and the flash controller (slave)
interface flash_wb_reader_if
   import flash_wb_reader_pkg::*;
#(
   parameter int ADDR_W = FLASH_ADDR_W,
   parameter int DATA_W = FLASH_DATA_W
);
   logic              cyc;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_w;
   logic              stall;
   logic              ack;
   logic [DATA_W-1:0] dat_r;
   modport master (output cyc, stb, we, adr, dat_w, input stall, ack, dat_r);
   modport slave  (input cyc, stb, we, adr, dat_w, output stall, ack, dat_r);
endinterface

// File: rtl/flash_wb_reader_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and synchronous flush
module sync_fifo
   import flash_wb_reader_pkg::*;
#(
   parameter int DATA_W    = FLASH_DATA_W,
   parameter int FIFO_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 push,
   input  logic [DATA_W-1:0]    wdata,
   input  logic                 pop,
   output logic [DATA_W-1:0]    rdata,
   output logic                 valid,
   output logic [FIFO_LOG2:0]   count
);
   localparam int DEPTH = 2 ** FIFO_LOG2;
   logic [DATA_W-1:0]    mem [DEPTH];
   logic [FIFO_LOG2-1:0] wptr, rptr;
   logic                 wr, rd;
   assign valid = count != '0;
   assign rd    = pop && valid;
   // a push into a full FIFO is fine when the head leaves in the same cycle
   assign wr    = push && (count != (FIFO_LOG2 + 1)'(DEPTH) || rd);
   assign rdata = valid ? mem[rptr] : '0;
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= wdata;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + FIFO_LOG2'(wr);
         rptr  <= rptr + FIFO_LOG2'(rd);
         count <= count + (FIFO_LOG2 + 1)'(wr) - (FIFO_LOG2 + 1)'(rd);
      end
endmodule

// File: rtl/flash_wb_reader.sv
// flash_wb_reader: Wishbone pipelined master that reads a block of flash words and streams them out
module flash_wb_reader
   import flash_wb_reader_pkg::*;
#(
   parameter int ADDR_W    = FLASH_ADDR_W,
   parameter int DATA_W    = FLASH_DATA_W,
   parameter int LEN_W     = 16,
   parameter int FIFO_LOG2 = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   flash_wb_reader_if.master wb,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   input  logic              ready
);
   localparam int DEPTH = 2 ** FIFO_LOG2;
   localparam int TW    = $clog2(TIMEOUT + 1);
   state_t             state, state_nx;
   logic [ADDR_W-1:0]  adr_r;
   logic [LEN_W-1:0]   len_r, issued, received, outs;
   logic [TW-1:0]      tmo;
   logic [FIFO_LOG2:0] count;
   logic               run, req, accept, push, last, expire, go, done_nx;
   assign run    = state == ST_RUN;
   assign outs   = issued - received;
   // every request in flight already owns a FIFO slot, so an ack can never be dropped
   assign req    = run && issued != len_r && outs + LEN_W'(count) < LEN_W'(DEPTH);
   assign accept = req && !wb.stall;
   assign push   = run && wb.ack;
   assign last   = push && received + LEN_W'(1) == len_r;
   assign expire = run && !wb.ack && outs != '0 && tmo == TW'(TIMEOUT);
   assign go     = state == ST_IDLE && start && !abort && len != '0;
   assign busy   = state != ST_IDLE;
   assign wb.cyc   = run;
   assign wb.stb   = req;
   assign wb.we    = 1'b0;
   assign wb.adr   = adr_r;
   assign wb.dat_w = '0;
   sync_fifo #(.DATA_W(DATA_W), .FIFO_LOG2(FIFO_LOG2)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort || expire),
      .push  (push),
      .wdata (wb.dat_r),
      .pop   (valid && ready),
      .rdata (data),
      .valid (valid),
      .count (count)
   );
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      if (abort) state_nx = ST_IDLE;
      else if (state == ST_IDLE) begin
         state_nx = go ? ST_RUN : ST_IDLE;
         done_nx  = start && len == '0;
      end else if (state == ST_RUN) begin
         state_nx = expire ? ST_IDLE : last ? ST_DRAIN : ST_RUN;
         done_nx  = expire;
      end else begin
         state_nx = count == '0 ? ST_IDLE : ST_DRAIN;
         done_nx  = count == '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= ST_IDLE;
         done     <= 1'b0;
         err      <= 1'b0;
         adr_r    <= '0;
         len_r    <= '0;
         issued   <= '0;
         received <= '0;
         tmo      <= '0;
      end else begin
         state <= state_nx;
         done  <= done_nx;
         err   <= go ? 1'b0 : expire && !abort ? 1'b1 : err;
         if (go) begin
            adr_r    <= addr;
            len_r    <= len;
            issued   <= '0;
            received <= '0;
         end else begin
            if (accept) begin
               adr_r  <= adr_r + ADDR_W'(1);
               issued <= issued + LEN_W'(1);
            end
            if (push) received <= received + LEN_W'(1);
         end
         tmo <= push || !run || outs == '0 ? '0 : tmo + TW'(1);
      end
endmodule
